shiftreg_bringup_param: RTL and testbench

- Parametrised successor to the FPGA shift-register bring-up top level.
- Debounces and synchronises raw board inputs: load button, serial-data switch, shift-clock switch, and a new direction switch.
- Drives a WIDTH-bit bidirectional shift register, plus a shift counter and full flag.
- Sits directly under the board top level; parallel_in comes from slide switches, parallel_out goes to LEDs.

---
 rtl/shiftreg_bringup_param_if.sv | 42 ++++
 rtl/shiftreg_bringup_param.sv | 141 ++++++++++++++
 tb/tb_shiftreg_bringup_param.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_bringup_param_if.sv
// Board-side bundle for the shift-register bring-up block.
//   master : board/testbench side, drives the raw switches, button and parallel_in
//   slave  : shift-register block, drives parallel_out, serial_out, shift_count, full
// When SHIFTREG_ROTATE_EN is defined, the bundle also carries the raw rotate_sw switch.
`timescale 1ns/1ps
interface shiftreg_bringup_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             load_btn;
  logic             serial_sw;
  logic             shift_sw;
  logic             dir_sw;
`ifdef SHIFTREG_ROTATE_EN
  logic             rotate_sw;
`endif
  logic [WIDTH-1:0] parallel_in;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out;
  logic [CNT_W-1:0] shift_count;
  logic             full;

`ifdef SHIFTREG_ROTATE_EN
  modport master (
    output load_btn, serial_sw, shift_sw, dir_sw, rotate_sw, parallel_in,
    input  parallel_out, serial_out, shift_count, full
  );
  modport slave (
    input  load_btn, serial_sw, shift_sw, dir_sw, rotate_sw, parallel_in,
    output parallel_out, serial_out, shift_count, full
  );
`else
  modport master (
    output load_btn, serial_sw, shift_sw, dir_sw, parallel_in,
    input  parallel_out, serial_out, shift_count, full
  );
  modport slave (
    input  load_btn, serial_sw, shift_sw, dir_sw, parallel_in,
    output parallel_out, serial_out, shift_count, full
  );
`endif
endinterface

// File: rtl/shiftreg_bringup_param.sv
// Parametrised shift-register bring-up block. Each raw board input is conditioned by a
// two-flop synchroniser followed by a debounce counter. The conditioned edge pulses and
// levels then drive a WIDTH-bit bidirectional shift register, a saturating shift counter,
// and a full flag.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : shiftreg_bringup_param_if.slave. Carries the raw load_btn, serial_sw,
//              shift_sw and dir_sw inputs (plus rotate_sw when enabled) and parallel_in.
//              Returns parallel_out, serial_out, shift_count and full.
// Optional feature macro: SHIFTREG_ROTATE_EN. It adds rotate_sw. While rotate_sw's
// conditioned level is high, each shift feeds serial_out back in, so the register rotates.
`timescale 1ns/1ps
module shiftreg_bringup_param #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned CNT_W           = 4
) (
  input logic                     clk,
  input logic                     reset_n,
  shiftreg_bringup_param_if.slave bus
);

  localparam int unsigned IdxLoad  = 0;
  localparam int unsigned IdxSer   = 1;
  localparam int unsigned IdxShift = 2;
  localparam int unsigned IdxDir   = 3;
`ifdef SHIFTREG_ROTATE_EN
  localparam int unsigned IdxRot   = 4;
  localparam int unsigned NumIn    = 5;
`else
  localparam int unsigned NumIn    = 4;
`endif

  localparam int unsigned     CntDbW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntDbW-1:0] DbLast = CntDbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntMax = CNT_W'(WIDTH);

  logic [NumIn-1:0] w_raw;
`ifdef SHIFTREG_ROTATE_EN
  assign w_raw = {bus.rotate_sw, bus.dir_sw, bus.shift_sw, bus.serial_sw, bus.load_btn};
`else
  assign w_raw = {bus.dir_sw, bus.shift_sw, bus.serial_sw, bus.load_btn};
`endif

  // Conditioner state, one slot per raw input
  logic [NumIn-1:0]  r_sync1;
  logic [NumIn-1:0]  r_sync2;
  logic [NumIn-1:0]  r_level;
  logic [NumIn-1:0]  r_rise;
  logic [NumIn-1:0]  r_fall;
  logic [CntDbW-1:0] r_dbcnt [NumIn];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int unsigned i = 0; i < NumIn; i++) begin
        r_dbcnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int unsigned i = 0; i < NumIn; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_dbcnt[i] <= '0;
        end else if (r_dbcnt[i] == DbLast) begin
          // The level and its edge pulse update together, so both are visible in the
          // same cycle.
          r_level[i] <= r_sync2[i];
          r_dbcnt[i] <= '0;
          r_rise[i]  <= r_sync2[i];
          r_fall[i]  <= ~r_sync2[i];
        end else begin
          r_dbcnt[i] <= r_dbcnt[i] + 1'b1;
        end
      end
    end
  end

  // Shift register datapath
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_d;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_d;
  logic             w_serial_out;
  logic             w_shift_in;

  assign w_serial_out = r_level[IdxDir] ? r_data[0] : r_data[WIDTH-1];

`ifdef SHIFTREG_ROTATE_EN
  assign w_shift_in = r_level[IdxRot] ? w_serial_out : r_level[IdxSer];
`else
  assign w_shift_in = r_level[IdxSer];
`endif

  always_comb begin
    w_data_d  = r_data;
    w_count_d = r_count;
    if (r_fall[IdxLoad]) begin
      // A load takes priority over a shift in the same cycle.
      w_data_d  = bus.parallel_in;
      w_count_d = '0;
    end else if (r_rise[IdxShift]) begin
      if (r_level[IdxDir]) begin
        w_data_d = {w_shift_in, r_data[WIDTH-1:1]};
      end else begin
        w_data_d = {r_data[WIDTH-2:0], w_shift_in};
      end
      // The count saturates, but shifting continues past that point.
      if (r_count != CntMax) begin
        w_count_d = r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_data  <= w_data_d;
      r_count <= w_count_d;
    end
  end

  assign bus.parallel_out = r_data;
  assign bus.serial_out   = w_serial_out;
  assign bus.shift_count  = r_count;
  assign bus.full         = (r_count == CntMax);

  // The datapath only uses some of the conditioned levels and pulses.
  logic w_unused;
  assign w_unused = ^{r_level, r_rise, r_fall};

endmodule

// File: tb/tb_shiftreg_bringup_param.sv
`timescale 1ns/1ps
module tb_shiftreg_bringup_param;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 3;
  localparam int unsigned CW = 4;
  localparam int LOAD = 0, SER = 1, SHIFT = 2, DIR = 3, ROT = 4, NIN = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NIN-1:0] raw;
  logic [W-1:0]   pin;

  shiftreg_bringup_param_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  assign bus.load_btn    = raw[LOAD];
  assign bus.serial_sw   = raw[SER];
  assign bus.shift_sw    = raw[SHIFT];
  assign bus.dir_sw      = raw[DIR];
`ifdef SHIFTREG_ROTATE_EN
  assign bus.rotate_sw   = raw[ROT];
`endif
  assign bus.parallel_in = pin;

  shiftreg_bringup_param #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. A conditioned level flips to v once the D synchronised samples seen
  // by the debouncer all equal v, while the level is still ~v. The synchronised sample at
  // edge e is the raw value taken at edge e-2.
  logic [63:0]    m_hist [NIN];  // bit j = raw sample from edge (now-1-j)
  logic [NIN-1:0] m_cond, m_rise, m_fall;
  logic [W-1:0]   m_data;
  int             m_cnt;

  function automatic logic m_so();
    return m_cond[DIR] ? m_data[0] : m_data[W-1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NIN; i++) m_hist[i] = '0;
    m_cond = '0;
    m_rise = '0;
    m_fall = '0;
    m_data = '0;
    m_cnt  = 0;
  endtask

  task automatic model_step();
    logic           bin, rot;
    logic [D-1:0]   win;
    logic [NIN-1:0] nc, nr, nf;
    rot = 1'b0;
`ifdef SHIFTREG_ROTATE_EN
    rot = m_cond[ROT];
`endif
    if (m_fall[LOAD]) begin
      m_data = pin;
      m_cnt  = 0;
    end else if (m_rise[SHIFT]) begin
      bin = rot ? m_so() : m_cond[SER];
      if (m_cond[DIR]) m_data = (m_data >> 1) | (W'(bin) << (W - 1));
      else             m_data = (m_data << 1) | W'(bin);
      if (m_cnt < W) m_cnt++;
    end
    for (int i = 0; i < NIN; i++) begin
      nc[i] = m_cond[i];
      nr[i] = 1'b0;
      nf[i] = 1'b0;
      win = m_hist[i][D:1];
      if (win == {D{~m_cond[i]}}) begin
        nc[i] = ~m_cond[i];
        nr[i] = nc[i];
        nf[i] = ~nc[i];
      end
      m_hist[i] = {m_hist[i][62:0], raw[i]};
    end
    m_cond = nc;
    m_rise = nr;
    m_fall = nf;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("parallel_out", bus.parallel_out, m_data);
    check("serial_out", bus.serial_out, m_so());
    check("shift_count", bus.shift_count, m_cnt);
    check("full", bus.full, m_cnt == W);
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("reset parallel_out", bus.parallel_out, 0);
    check("reset serial_out", bus.serial_out, 0);
    check("reset shift_count", bus.shift_count, 0);
    check("reset full", bus.full, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic do_load(input logic [W-1:0] d);
    pin = d;
    raw[LOAD] = 1'b1;
    hold(8);
    raw[LOAD] = 1'b0;
    hold(8);
  endtask

  task automatic do_shift(input logic ser, input logic dir);
    raw[SER] = ser;
    raw[DIR] = dir;
    hold(8);
    raw[SHIFT] = 1'b1;
    hold(8);
    raw[SHIFT] = 1'b0;
    hold(8);
  endtask

  typedef enum {OpLoad, OpShift, OpDir} op_e;
  typedef struct {
    op_e          op;
    logic [W-1:0] pin;
    logic         ser;
    logic         dir;
    logic [W-1:0] e_data;
    int           e_cnt;
    logic         e_full;
    logic         e_so;
  } vec_t;
  vec_t vecs[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OpLoad,  8'hA5, 1'b0, 1'b0, 8'hA5, 0, 1'b0, 1'b1};
    vecs[1]  = '{OpShift, 8'h00, 1'b1, 1'b0, 8'h4B, 1, 1'b0, 1'b0};
    vecs[2]  = '{OpLoad,  8'h81, 1'b0, 1'b0, 8'h81, 0, 1'b0, 1'b1};
    vecs[3]  = '{OpShift, 8'h00, 1'b0, 1'b1, 8'h40, 1, 1'b0, 1'b0};
    vecs[4]  = '{OpShift, 8'h00, 1'b0, 1'b1, 8'h20, 2, 1'b0, 1'b0};
    vecs[5]  = '{OpShift, 8'h00, 1'b0, 1'b1, 8'h10, 3, 1'b0, 1'b0};
    vecs[6]  = '{OpShift, 8'h00, 1'b0, 1'b1, 8'h08, 4, 1'b0, 1'b0};
    vecs[7]  = '{OpShift, 8'h00, 1'b0, 1'b1, 8'h04, 5, 1'b0, 1'b0};
    vecs[8]  = '{OpShift, 8'h00, 1'b0, 1'b1, 8'h02, 6, 1'b0, 1'b0};
    vecs[9]  = '{OpShift, 8'h00, 1'b0, 1'b1, 8'h01, 7, 1'b0, 1'b1};
    vecs[10] = '{OpShift, 8'h00, 1'b0, 1'b1, 8'h00, 8, 1'b1, 1'b0};
    vecs[11] = '{OpShift, 8'h00, 1'b0, 1'b1, 8'h00, 8, 1'b1, 1'b0};
    vecs[12] = '{OpShift, 8'h00, 1'b1, 1'b1, 8'h80, 8, 1'b1, 1'b0};
    vecs[13] = '{OpShift, 8'h00, 1'b1, 1'b0, 8'h01, 8, 1'b1, 1'b0};
    vecs[14] = '{OpLoad,  8'h01, 1'b0, 1'b0, 8'h01, 0, 1'b0, 1'b0};
    vecs[15] = '{OpDir,   8'h00, 1'b0, 1'b1, 8'h01, 0, 1'b0, 1'b1};
    vecs[16] = '{OpDir,   8'h00, 1'b0, 1'b0, 8'h01, 0, 1'b0, 1'b0};
    vecs[17] = '{OpShift, 8'h00, 1'b1, 1'b1, 8'h80, 1, 1'b0, 1'b0};

    reset_n = 1'b0;
    raw     = '0;
    pin     = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("init parallel_out", bus.parallel_out, 0);
    check("init serial_out", bus.serial_out, 0);
    check("init shift_count", bus.shift_count, 0);
    check("init full", bus.full, 0);
    reset_n = 1'b1;

    // Debounce latency: raw set before edge k, pulse at k+4, register update at k+5
    raw[SHIFT] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("latency early count", bus.shift_count, 0);
    end
    tick();
    check("latency count", bus.shift_count, 1);
    hold(8);
    check("single pulse count", bus.shift_count, 1);

    // Glitch rejection: two cycles high is too short to register
    pin = 8'hFF;
    raw[LOAD] = 1'b1;
    hold(2);
    raw[LOAD] = 1'b0;
    hold(10);
    check("glitch parallel_out", bus.parallel_out, 8'h00);
    check("glitch shift_count", bus.shift_count, 1);

    // Coincident load and shift pulses
    raw[SHIFT] = 1'b0;
    hold(8);
    raw[LOAD] = 1'b1;
    hold(8);
    pin = 8'h5A;
    raw[LOAD]  = 1'b0;
    raw[SHIFT] = 1'b1;
    hold(8);
    check("coincident parallel_out", bus.parallel_out, 8'h5A);
    check("coincident shift_count", bus.shift_count, 0);

    // Asynchronous reset between edges
    raw[SHIFT] = 1'b0;
    hold(8);
    do_load(8'hFF);
    check("preload parallel_out", bus.parallel_out, 8'hFF);
    async_reset();
    hold(2);

    // Table-driven operations
    for (int v = 0; v < 18; v++) begin
      unique case (vecs[v].op)
        OpLoad:  do_load(vecs[v].pin);
        OpShift: do_shift(vecs[v].ser, vecs[v].dir);
        default: begin
          raw[DIR] = vecs[v].dir;
          hold(8);
        end
      endcase
      check($sformatf("vec%0d parallel_out", v), bus.parallel_out, vecs[v].e_data);
      check($sformatf("vec%0d shift_count", v), bus.shift_count, vecs[v].e_cnt);
      check($sformatf("vec%0d full", v), bus.full, vecs[v].e_full);
      check($sformatf("vec%0d serial_out", v), bus.serial_out, vecs[v].e_so);
    end

`ifdef SHIFTREG_ROTATE_EN
    // Rotate left: 0x81 becomes 0x03 with serial_sw low
    do_load(8'h81);
    raw[ROT] = 1'b1;
    do_shift(1'b0, 1'b0);
    check("rotate parallel_out", bus.parallel_out, 8'h03);
    raw[ROT] = 1'b0;
    hold(8);
`endif

    // Randomised segments against the model
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) async_reset();
      for (int i = 0; i < NIN; i++) begin
        if ($urandom_range(0, 2) == 0) raw[i] = ~raw[i];
      end
      pin = W'($urandom);
      hold($urandom_range(1, 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
